// File: rtl/hs_sync_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : hs_sync_rx_if
//  Purpose  : Bundles the toggle req/ack bundled-data handshake with the
//             initiator and the valid/ready word stream to the downstream
//             consumer of hs_sync_rx.
//  Signals  : req_tgl     initiator -> responder, one toggle per word
//             data_async  initiator -> responder, held stable until ack seen
//             par_in      initiator -> responder, even parity (HSRX_PARITY_EN)
//             ack_tgl     responder -> initiator, one toggle per accepted word
//             out_data    responder -> consumer, captured word
//             out_valid   responder -> consumer, out_data valid
//             out_ready   consumer  -> responder, word accepted when high
//  Modports : master = initiator + consumer side, slave = hs_sync_rx
//  Config   : HSRX_PARITY_EN adds par_in
//  Revision : 1.0  initial release
// ============================================================================
interface hs_sync_rx_if #(
    parameter int N = 8
);
    logic         req_tgl;
    logic [N-1:0] data_async;
    logic         ack_tgl;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef HSRX_PARITY_EN
    logic         par_in;

    modport master (
        output req_tgl, data_async, par_in, out_ready,
        input  ack_tgl, out_data, out_valid
    );
    modport slave (
        input  req_tgl, data_async, par_in, out_ready,
        output ack_tgl, out_data, out_valid
    );
`else
    modport master (
        output req_tgl, data_async, out_ready,
        input  ack_tgl, out_data, out_valid
    );
    modport slave (
        input  req_tgl, data_async, out_ready,
        output ack_tgl, out_data, out_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hs_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module   : hs_sync_rx
//  Purpose  : clk-domain responder of a toggle req/ack bundled-data handshake.
//             Synchronizes the req toggle, captures the held data bus on the
//             detected toggle, presents it as a valid/ready word and returns
//             an ack toggle once the word has been accepted downstream.
//  Ports    : clk       destination clock
//             rst_n     asynchronous active-low reset (shared with initiator)
//             hs        hs_sync_rx_if.slave (req/data/ack + valid/ready word)
//             clr_ovr   synchronous clear of the sticky overrun / par_err
//             xfer_cnt  completed transfers, wraps modulo 2^CNT_W
//             overrun   sticky: req toggle seen while a word was pending
//             par_err   sticky parity error (HSRX_PARITY_EN only)
//  Config   : HSRX_PARITY_EN enables par_in checking and the par_err port
//  Revision : 1.0  initial release
// ============================================================================
module hs_sync_rx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    hs_sync_rx_if.slave           hs,
    input  wire logic             clr_ovr,
    output logic [CNT_W-1:0]      xfer_cnt,
`ifdef HSRX_PARITY_EN
    output logic                  par_err,
`endif
    output logic                  overrun
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_seen;
    logic                   w_edge;
    logic [N-1:0]           r_out_data;
    logic [N-1:0]           w_out_data_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic                   r_ack_tgl;
    logic                   w_ack_tgl_nxt;
    logic [CNT_W-1:0]       r_xfer_cnt;
    logic [CNT_W-1:0]       w_xfer_cnt_nxt;
    logic                   r_overrun;
    logic                   w_overrun_nxt;
`ifdef HSRX_PARITY_EN
    logic                   r_par_err;
    logic                   w_par_err_nxt;
`endif

    // Only the first flop of the chain ever looks at the asynchronous req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_req_seen <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], hs.req_tgl};
            r_req_seen <= r_sync[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse per req toggle; data_async is guaranteed stable here.
    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_req_seen;

    always_comb begin
        w_state_nxt     = r_state;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_ack_tgl_nxt   = r_ack_tgl;
        w_xfer_cnt_nxt  = r_xfer_cnt;
        w_overrun_nxt   = r_overrun;
`ifdef HSRX_PARITY_EN
        w_par_err_nxt   = r_par_err;
        if (clr_ovr) begin
            w_par_err_nxt = 1'b0;
        end
`endif
        // Clear first so a simultaneous set below takes priority.
        if (clr_ovr) begin
            w_overrun_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_out_data_nxt  = hs.data_async;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_VALID;
`ifdef HSRX_PARITY_EN
                    if (^{hs.data_async, hs.par_in}) begin
                        w_par_err_nxt = 1'b1;
                    end
`endif
                end
            end
            ST_VALID: begin
                // A new word while one is pending is dropped, only flagged.
                if (w_edge) begin
                    w_overrun_nxt = 1'b1;
                end
                if (hs.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_ack_tgl_nxt   = ~r_ack_tgl;
                    w_xfer_cnt_nxt  = r_xfer_cnt + 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ack_tgl   <= 1'b0;
            r_xfer_cnt  <= '0;
            r_overrun   <= 1'b0;
`ifdef HSRX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_ack_tgl   <= w_ack_tgl_nxt;
            r_xfer_cnt  <= w_xfer_cnt_nxt;
            r_overrun   <= w_overrun_nxt;
`ifdef HSRX_PARITY_EN
            r_par_err   <= w_par_err_nxt;
`endif
        end
    end

    assign hs.out_data  = r_out_data;
    assign hs.out_valid = r_out_valid;
    assign hs.ack_tgl   = r_ack_tgl;
    assign xfer_cnt     = r_xfer_cnt;
    assign overrun      = r_overrun;
`ifdef HSRX_PARITY_EN
    assign par_err      = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_sync_rx
//  Purpose  : Directed self-checking bench for hs_sync_rx (reset, single
//             transfer latency, backpressure, overrun/clear, counter wrap,
//             optional parity).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hs_sync_rx;

    localparam int N           = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic             clk;
    logic             rst_n;
    logic             clr_ovr;
    logic [CNT_W-1:0] xfer_cnt;
    logic             overrun;
`ifdef HSRX_PARITY_EN
    logic             par_err;
`endif

    int tests;
    int fails;

    hs_sync_rx_if #(.N(N)) bus ();

    hs_sync_rx #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (bus),
        .clr_ovr  (clr_ovr),
        .xfer_cnt (xfer_cnt),
`ifdef HSRX_PARITY_EN
        .par_err  (par_err),
`endif
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req_tgl    = 1'b0;
        bus.data_async = 8'h00;
        bus.out_ready  = 1'b0;
        clr_ovr        = 1'b0;
`ifdef HSRX_PARITY_EN
        bus.par_in     = 1'b0;
`endif
        tick(); tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b0 || xfer_cnt !== 8'd0 ||
            overrun !== 1'b0 || bus.out_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_init: valid=%b ack=%b cnt=%0d ovr=%b data=%h, want all 0",
                     bus.out_valid, bus.ack_tgl, xfer_cnt, overrun, bus.out_data);
        end
        rst_n = 1'b1;
        // Bring a word A5 into VALID and hold it there.
        bus.data_async = 8'hA5;
`ifdef HSRX_PARITY_EN
        bus.par_in     = 1'b0;
`endif
        bus.req_tgl    = 1'b1;
        tick(); tick(); tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            fails++;
            $display("FAIL reset_pre_valid: valid=%b data=%h, want 1 a5", bus.out_valid, bus.out_data);
        end
        // Asynchronous assertion between clock edges.
        #2;
        rst_n       = 1'b0;
        bus.req_tgl = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b0 || xfer_cnt !== 8'd0 ||
            overrun !== 1'b0 || bus.out_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_async: valid=%b ack=%b cnt=%0d ovr=%b data=%h, want all 0",
                     bus.out_valid, bus.ack_tgl, xfer_cnt, overrun, bus.out_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b0 || xfer_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_idle: valid=%b ack=%b cnt=%0d, want 0 0 0",
                     bus.out_valid, bus.ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_single();
        bus.out_ready  = 1'b1;
        bus.data_async = 8'h3C;
`ifdef HSRX_PARITY_EN
        bus.par_in     = 1'b0;
`endif
        bus.req_tgl    = ~bus.req_tgl;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_k: valid=%b, want 0", bus.out_valid);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_k1: valid=%b, want 0", bus.out_valid);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.ack_tgl !== 1'b0) begin
            fails++;
            $display("FAIL single_k2: valid=%b data=%h ack=%b, want 1 3c 0",
                     bus.out_valid, bus.out_data, bus.ack_tgl);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b1 || xfer_cnt !== 8'd1) begin
            fails++;
            $display("FAIL single_done: valid=%b ack=%b cnt=%0d, want 0 1 1",
                     bus.out_valid, bus.ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready  = 1'b0;
        bus.data_async = 8'h3C;
        bus.req_tgl    = ~bus.req_tgl;
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.ack_tgl !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ack=%b, want 1 3c 1",
                         i, bus.out_valid, bus.out_data, bus.ack_tgl);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b0 || xfer_cnt !== 8'd2) begin
            fails++;
            $display("FAIL bp_release: valid=%b ack=%b cnt=%0d, want 0 0 2",
                     bus.out_valid, bus.ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_overrun();
        bus.out_ready  = 1'b0;
        bus.data_async = 8'h11;
        bus.req_tgl    = ~bus.req_tgl;
        tick(); tick(); tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_first: valid=%b data=%h ovr=%b, want 1 11 0",
                     bus.out_valid, bus.out_data, overrun);
        end
        bus.data_async = 8'h77;
        bus.req_tgl    = ~bus.req_tgl;
        tick(); tick(); tick();
        tests++;
        if (overrun !== 1'b1 || bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovr_set: ovr=%b data=%h valid=%b, want 1 11 1",
                     overrun, bus.out_data, bus.out_valid);
        end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: ovr=%b, want 0", overrun);
        end
        // Clear lands on the same edge the synchronized toggle is acted on.
        bus.req_tgl = ~bus.req_tgl;
        tick(); tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_set_wins: ovr=%b, want 1", overrun);
        end
        bus.out_ready = 1'b1;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h11 || xfer_cnt !== 8'd3 ||
            bus.ack_tgl !== 1'b1) begin
            fails++;
            $display("FAIL ovr_drain: valid=%b data=%h cnt=%0d ack=%b, want 0 11 3 1",
                     bus.out_valid, bus.out_data, xfer_cnt, bus.ack_tgl);
        end
    endtask

    task automatic test_wrap();
        logic       exp_ack;
        logic [7:0] word;
        int         wait_cyc;
        int         word_fails;
        // Fresh start: initiator and responder reset together.
        #3;
        rst_n       = 1'b0;
        bus.req_tgl = 1'b0;
        clr_ovr     = 1'b0;
        tick(); tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        exp_ack    = 1'b0;
        word_fails = 0;
        for (int i = 0; i < 256; i++) begin
            word           = 8'($urandom);
            bus.data_async = word;
`ifdef HSRX_PARITY_EN
            bus.par_in     = ^word;
`endif
            #($urandom_range(1, 13));
            bus.req_tgl = ~bus.req_tgl;
            wait_cyc = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && wait_cyc < 20) begin
                @(negedge clk);
                wait_cyc++;
            end
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== word) begin
                fails++;
                word_fails++;
                if (word_fails < 5)
                    $display("FAIL wrap_word[%0d]: valid=%b data=%h, want 1 %h",
                             i, bus.out_valid, bus.out_data, word);
            end
            exp_ack  = ~exp_ack;
            wait_cyc = 0;
            while (bus.ack_tgl !== exp_ack && wait_cyc < 20) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (bus.ack_tgl !== exp_ack) begin
                tests++;
                fails++;
                $display("FAIL wrap_ack[%0d]: ack=%b, want %b", i, bus.ack_tgl, exp_ack);
            end
            if (i == 254) begin
                tests++;
                if (xfer_cnt !== 8'd255) begin
                    fails++;
                    $display("FAIL wrap_cnt255: cnt=%0d, want 255", xfer_cnt);
                end
            end
            #($urandom_range(0, 17));
        end
        tick();
        tests++;
        if (xfer_cnt !== 8'd0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL wrap_end: cnt=%0d ovr=%b, want 0 0", xfer_cnt, overrun);
        end
    endtask

`ifdef HSRX_PARITY_EN
    task automatic test_parity();
        bus.out_ready = 1'b1;
        clr_ovr       = 1'b1;
        tick();
        clr_ovr = 1'b0;
        bus.data_async = 8'h01;
        bus.par_in     = 1'b1;
        bus.req_tgl    = ~bus.req_tgl;
        tick(); tick(); tick();
        tests++;
        if (par_err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
            fails++;
            $display("FAIL par_good: perr=%b valid=%b data=%h, want 0 1 01",
                     par_err, bus.out_valid, bus.out_data);
        end
        tick();
        bus.par_in  = 1'b0;
        bus.req_tgl = ~bus.req_tgl;
        tick(); tick(); tick();
        tests++;
        if (par_err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
            fails++;
            $display("FAIL par_bad: perr=%b valid=%b data=%h, want 1 1 01",
                     par_err, bus.out_valid, bus.out_data);
        end
        tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tests++;
        if (par_err !== 1'b0) begin
            fails++;
            $display("FAIL par_clear: perr=%b, want 0", par_err);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_overrun();
        test_wrap();
`ifdef HSRX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
